rr_dec_arbiter: RTL
===================

# rr_dec_arbiter

Eight-way round-robin arbiter that shares a single 3-to-8 one-hot select resource between eight requesters. It keeps a registered 3-bit owner index and drives the one-hot grant bus through a 3-to-8 decoder stage, so at most one grant line is ever high. A programmable hold limit bounds how long one owner may keep the resource while others wait. A one-cycle dead gap separates consecutive owners.

## Interface
- HOLD_MAX, default 4: maximum consecutive grant cycles before forced rotation when other requests are pending; 0 = unlimited.
- CLK  in  1  rising-edge clock.
- RST_N  in  1  synchronous, active-low reset.
- REQ  in  8  request per requester; bit i = requester i; level-sensitive.
- GNT  out  8  one-hot grant, registered; all-zero when no owner.
- GNT_IDX  out  3  index of current owner; valid only while GNT_VALID=1.
- GNT_VALID  out  1  high while any GNT bit is high.
- BUSY  out  1  high in GRANT and SWITCH states.

## Operation
- State machine states:
  - IDLE: no owner.
  - GRANT: owner GNT_IDX holds the resource.
  - SWITCH: one-cycle gap with all GNT low.
- Winner selection (combinational, from REQ in the current cycle):
  - Search indices PTR, PTR+1, …, PTR+7 mod 8; the first set bit wins.
  - PTR is a 3-bit rotation pointer.
- IDLE:
  - If REQ≠0: go to GRANT, GNT_IDX←winner, PTR←winner+1 mod 8, HCNT←1.
  - Otherwise stay in IDLE.
- GRANT, evaluated in priority order:
  - REQ[GNT_IDX]=0 (release): go to SWITCH.
  - HOLD_MAX≠0, HCNT==HOLD_MAX and any other REQ bit set: go to SWITCH (forced rotation).
  - Otherwise stay in GRANT; HCNT increments and saturates at HOLD_MAX.
- SWITCH:
  - If REQ≠0: go to GRANT with a new winner (same update as IDLE).
  - Otherwise go to IDLE.
  - The previous owner is now lowest priority, because PTR already points past it.
- Output derivation:
  - GNT = decode(GNT_IDX) gated by GNT_VALID.
  - GNT_VALID = (state==GRANT).
  - BUSY = (state≠IDLE).
- HCNT width is clog2(HOLD_MAX+1), minimum 1 bit. HCNT is unused when HOLD_MAX=0.
- Boundary cases:
  - Release and hold expiry in the same cycle are treated as a release; the result is identical (SWITCH).
  - Owner alone with expired HCNT: the grant is kept and HCNT stays at HOLD_MAX.
  - PTR wrap: 7+1 wraps to 0.
  - A REQ bit dropped before it is granted is simply not considered. There is no request latching.
  - Reset mid-grant: the next CLK edge with RST_N=0 forces reset values regardless of state.

## Timing
- Reset values:
  - state=IDLE, PTR=0, HCNT=0.
  - GNT=8'h00, GNT_IDX=3'd0, GNT_VALID=0, BUSY=0.
- Grant latency:
  - REQ sampled at edge k in IDLE gives GNT valid after edge k (one cycle).
  - Release or expiry sampled at edge m gives GNT=0 after m and the next owner after m+1.
- With HOLD_MAX=H and contention, the owner holds exactly H cycles, then 1 gap cycle.
- All outputs are registered or decoded from registered state only. There is no combinational REQ→GNT path.

## Structure
- Package rr_dec_pkg contains:
  - N_REQ=8 and IDX_W=3.
  - State enum {IDLE, GRANT, SWITCH}.
  - Function next_rr(req, ptr) returning the winner index.
- Sub-module dec3to8_en (inputs IDX[2:0], EN; output Y[7:0]): purely combinational one-hot decoder. It is instantiated once to drive GNT.

## Test plan
- Reset: hold RST_N=0 for 2 cycles with REQ=8'hFF. Required: GNT=8'h00, GNT_VALID=0, BUSY=0; first grant after release goes to index 0.
- Single requester: REQ=8'h08 for 10 cycles, HOLD_MAX=4.
  - GNT=8'h08 from cycle 1 through cycle 10; no gap, because there is no contention.
  - After REQ drops: one SWITCH cycle, then IDLE.
- Forced rotation: REQ=8'h05 held constant, HOLD_MAX=4.
  - GNT=8'h01 for 4 cycles, 1 cycle of 8'h00, then 8'h04 for 4 cycles, then 1 gap, then 8'h01 again.
- Full contention wrap: REQ=8'hFF, HOLD_MAX=1. Grants are 0,1,…,7,0, each 1 cycle with 1-cycle gaps; PTR wraps from 7 to 0.
- Simultaneous release and expiry: REQ=8'h03, owner 0 drops REQ[0] in the cycle HCNT==4.
  - Exactly one gap cycle, then GNT=8'h02.
  - Then RST_N=0 mid-grant: GNT=8'h00 at the next edge.

Source files
------------

// File: rtl/rr_dec_pkg.sv
// Shared types, sizes and the rotating-priority search for the round-robin decoder arbiter.
package rr_dec_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StSwitch
  } state_e;

  // First set request at or after ptr, wrapping modulo N_REQ; returns ptr when req is empty.
  function automatic logic [IDX_W-1:0] next_rr(input logic [N_REQ-1:0] req,
                                              input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] idx;
    next_rr = ptr;
    // Walk from the farthest offset down so the nearest set bit is assigned last.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = ptr + IDX_W'(i);
      if (req[idx]) next_rr = idx;
    end
  endfunction

endpackage

// File: rtl/dec3to8_en.sv
// Combinational 3-to-8 one-hot decoder with enable; output is all-zero when disabled.
module dec3to8_en
  import rr_dec_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [N_REQ-1:0] y
);

  always_comb begin
    y = '0;
    if (en) y = N_REQ'(1) << idx;
  end

endmodule

// File: rtl/rr_dec_arbiter.sv
// Eight-way round-robin arbiter with bounded hold time and a one-cycle gap between owners.
module rr_dec_arbiter
  import rr_dec_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             busy
);

  localparam int unsigned HcntW = (HOLD_MAX == 0) ? 1 : $clog2(HOLD_MAX + 1);
  localparam logic [HcntW-1:0] HcntMax = HcntW'(HOLD_MAX);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [HcntW-1:0] hcnt_q, hcnt_d;
  logic [IDX_W-1:0] winner;
  logic [N_REQ-1:0] others;

  assign winner = next_rr(req, ptr_q);
  assign others = req & ~(N_REQ'(1) << idx_q);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    hcnt_d  = hcnt_q;
    unique case (state_q)
      StIdle, StSwitch: begin
        if (|req) begin
          state_d = StGrant;
          idx_d   = winner;
          ptr_d   = winner + IDX_W'(1);
          hcnt_d  = HcntW'(1);
        end else begin
          state_d = StIdle;
        end
      end
      StGrant: begin
        if (!req[idx_q]) begin
          state_d = StSwitch;
        end else if ((HOLD_MAX != 0) && (hcnt_q == HcntMax) && (|others)) begin
          state_d = StSwitch;
        end else if ((HOLD_MAX != 0) && (hcnt_q != HcntMax)) begin
          hcnt_d = hcnt_q + HcntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      idx_q   <= '0;
      hcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      hcnt_q  <= hcnt_d;
    end
  end

  assign gnt_valid = (state_q == StGrant);
  assign busy      = (state_q != StIdle);
  assign gnt_idx   = idx_q;

  dec3to8_en u_dec (
    .idx (idx_q),
    .en  (gnt_valid),
    .y   (gnt)
  );

endmodule
